// File: rtl/tt_serial_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings, ui_in/uo_out bit map, width limit.
package tt_serial_pkg;
  localparam int MAX_WIDTH = 8;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int UI_A     = 0;
  localparam int UI_B     = 1;
  localparam int UI_VLD   = 2;
  localparam int UI_START = 3;
  localparam int UI_CLR   = 4;
  localparam int UI_MODE  = 5;

  localparam int UO_DIFF   = 0;
  localparam int UO_BORROW = 1;
  localparam int UO_VLD    = 2;
  localparam int UO_DONE   = 3;
  localparam int UO_UNDER  = 4;
  localparam int UO_IDX    = 5;
endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor; with ADD_MODE_EN defined, mode=1 turns it into a full adder.
module serial_sub_cell (
`ifdef ADD_MODE_EN
  input  logic mode,
`endif
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d = a ^ b ^ bin;
`ifdef ADD_MODE_EN
  // bin doubles as carry-in when adding
  assign bout = mode ? ((a & b) | ((a ^ b) & bin))
                     : ((~a & b) | (~(a ^ b) & bin));
`else
  assign bout = (~a & b) | (~(a ^ b) & bin);
`endif
endmodule

// File: rtl/tt_um_serial_sub.sv
// Bit-serial subtractor in the Tiny Tapeout wrapper: LSB-first bits in, registered diff bits out,
// completed words published on uio_out. ADD_MODE_EN adds a per-word add/subtract mode select.
module tt_um_serial_sub
  import tt_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  state_t               state;
  logic [3:0]           idx;
  logic                 borrow;
  logic [MAX_WIDTH-1:0] acc;
  logic [MAX_WIDTH-1:0] acc_nxt;
  logic [MAX_WIDTH-1:0] word;
  logic                 diff_q;
  logic                 vld_q;
  logic                 done_q;
  logic                 under_q;
  logic [2:0]           last_idx;

  logic a_bit, b_bit, in_vld, start, clr;
  logic start_bit, run_bit, take, cin, d, bout, last;
  logic [3:0] cur, nxt_idx;

  assign a_bit  = ui_in[UI_A];
  assign b_bit  = ui_in[UI_B];
  assign in_vld = ui_in[UI_VLD];
  assign start  = ui_in[UI_START];
  assign clr    = ui_in[UI_CLR];

  // A start always begins a fresh word, so it also aborts any word in progress
  assign start_bit = in_vld & start;
  assign run_bit   = in_vld & ~start & (state == RUN);
  assign take      = start_bit | run_bit;
  assign cin       = start_bit ? 1'b0 : borrow;
  assign cur       = start_bit ? 4'd0 : idx;
  assign nxt_idx   = cur + 4'd1;
  assign last      = (nxt_idx == 4'(WIDTH));

  always_comb begin
    acc_nxt = start_bit ? '0 : acc;
    acc_nxt[cur[2:0]] = d;
  end

`ifdef ADD_MODE_EN
  logic mode_q;
  logic mode_cur;
  logic unused_ok;
  assign mode_cur  = start_bit ? ui_in[UI_MODE] : mode_q;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         mode_q <= 1'b0;
    else if (clr)       mode_q <= 1'b0;
    else if (start_bit) mode_q <= ui_in[UI_MODE];
  end

  serial_sub_cell u_cell (
    .mode (mode_cur),
    .a    (a_bit),
    .b    (b_bit),
    .bin  (cin),
    .d    (d),
    .bout (bout)
  );
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:5]};

  serial_sub_cell u_cell (
    .a    (a_bit),
    .b    (b_bit),
    .bin  (cin),
    .d    (d),
    .bout (bout)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      borrow   <= 1'b0;
      acc      <= '0;
      word     <= '0;
      diff_q   <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      under_q  <= 1'b0;
      last_idx <= '0;
    end else if (clr) begin
      state    <= IDLE;
      idx      <= '0;
      borrow   <= 1'b0;
      acc      <= '0;
      word     <= '0;
      diff_q   <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      under_q  <= 1'b0;
      last_idx <= '0;
    end else begin
      vld_q  <= take;
      done_q <= 1'b0;
      if (take) begin
        diff_q   <= d;
        borrow   <= bout;
        last_idx <= cur[2:0];
        acc      <= acc_nxt;
        if (last) begin
          state   <= DONE;
          idx     <= '0;
          word    <= acc_nxt;
          under_q <= bout;
          done_q  <= 1'b1;
        end else begin
          state <= RUN;
          idx   <= nxt_idx;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

  always_comb begin
    uo_out               = '0;
    uo_out[UO_DIFF]      = diff_q;
    uo_out[UO_BORROW]    = borrow;
    uo_out[UO_VLD]       = vld_q;
    uo_out[UO_DONE]      = done_q;
    uo_out[UO_UNDER]     = under_q;
    uo_out[UO_IDX +: 3]  = last_idx;
  end

  assign uio_out = word;
  assign uio_oe  = 8'hFF;
endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Scoreboard bench for tt_um_serial_sub: arithmetic reference model feeds queues, a negedge monitor checks.
module tb_tt_um_serial_sub;
  localparam int W = 8;
`ifdef ADD_MODE_EN
  localparam bit HAS_ADD = 1'b1;
`else
  localparam bit HAS_ADD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_serial_sub #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  logic [4:0] bit_q[$];   // {index, borrow/carry, diff}
  logic [8:0] word_q[$];  // {word, underflow/carry}
  int done_cyc[$];
  int first_cyc;
  bit gap_chk = 1'b0;
  logic [4:0] last_exp = '0;
  logic [4:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Bit i of a-b (or a+b) and the borrow/carry out of the low i+1 bits, by plain arithmetic
  function automatic logic [4:0] exp_bit(input logic [7:0] a, input logic [7:0] b,
                                         input bit mode, input int i);
    int unsigned ai = a, bi = b, m = (32'd1 << (i + 1)) - 1, r;
    bit c;
    if (mode && HAS_ADD) begin
      r = ai + bi;
      c = ((ai & m) + (bi & m)) > m;
    end else begin
      r = ai - bi;
      c = (ai & m) < (bi & m);
    end
    return {3'(i % 8), c, 1'((r >> i) & 1)};
  endfunction

  function automatic logic [8:0] exp_word(input logic [7:0] a, input logic [7:0] b, input bit mode);
    int unsigned ai = a, bi = b, m = (32'd1 << W) - 1;
    if (mode && HAS_ADD) return {8'((ai + bi) & m), (ai + bi) > m};
    return {8'((ai - bi) & m), ai < bi};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ui_in = 8'($urandom) & 8'b1110_0011;
    end
  endtask

  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input bit mode,
                           input int nbits, input int gap_pct);
    for (int i = 0; i < nbits; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) idle(1);
      @(posedge clk); #1;
      ui_in = {2'b00, mode, 1'b0, (i == 0), 1'b1, b[i], a[i]};
      if (i == 0) first_cyc = cyc;
      bit_q.push_back(exp_bit(a, b, mode, i));
    end
    if (nbits == W) word_q.push_back(exp_word(a, b, mode));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (uo_out[2]) begin
        if (bit_q.size() == 0) check("unexpected_bit", 32'(uo_out[2]), 32'd0);
        else begin
          mon_e = bit_q.pop_front();
          check("bit", 32'({uo_out[7:5], uo_out[1:0]}), 32'(mon_e));
          last_exp = mon_e;
        end
      end else if (gap_chk) begin
        check("hold", 32'({uo_out[7:5], uo_out[1:0]}), 32'(last_exp));
      end
      if (uo_out[3]) begin
        done_cyc.push_back(cyc);
        if (word_q.size() == 0) check("unexpected_done", 32'(uo_out[3]), 32'd0);
        else check("word", 32'({uio_out, uo_out[4]}), 32'(word_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] ra, rb;
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("reset_uo_out", 32'(uo_out), 32'h00);
    check("reset_uio_out", 32'(uio_out), 32'h00);
    check("uio_oe", 32'(uio_oe), 32'hFF);
    rst_n = 1'b1;
    idle(2);

    done_cyc.delete();
    send_word(8'h05, 8'h03, 1'b0, W, 0);
    idle(3);
    check("w05_03", 32'({uio_out, uo_out[4]}), 32'({8'h02, 1'b0}));
    if (done_cyc.size() == 1) check("done_latency", 32'(done_cyc[0] - first_cyc), 32'(W));
    else check("done_count_1", 32'(done_cyc.size()), 32'd1);

    send_word(8'h03, 8'h05, 1'b0, W, 0);
    idle(3);
    check("w03_05", 32'({uio_out, uo_out[4], uo_out[1]}), 32'({8'hFE, 1'b1, 1'b1}));

    done_cyc.delete();
    send_word(8'hFF, 8'h01, 1'b0, W, 0);
    send_word(8'h10, 8'h10, 1'b0, W, 0);
    idle(3);
    check("b2b_count", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() == 2) check("b2b_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'(W));

    gap_chk = 1'b1;
    send_word(8'hA5, 8'h5A, 1'b0, W, 40);
    idle(2);
    gap_chk = 1'b0;
    check("wA5_5A", 32'(uio_out), 32'h4B);

    send_word(8'h01, 8'h02, 1'b0, 3, 0);
    send_word(8'h07, 8'h02, 1'b0, W, 0);
    idle(3);
    check("abort_restart", 32'({uio_out, uo_out[4]}), 32'({8'h05, 1'b0}));

    send_word(8'h3C, 8'h11, 1'b0, 4, 0);
    idle(2);
    rst_n = 1'b0;
    #1;
    check("midword_rst_uo", 32'(uo_out), 32'h00);
    check("midword_rst_uio", 32'(uio_out), 32'h00);
    last_exp = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_word(8'h09, 8'h02, 1'b0, W, 0);
    idle(3);
    check("post_rst_word", 32'(uio_out), 32'h07);

    send_word(8'h55, 8'h0F, 1'b0, 3, 0);
    @(posedge clk); #1;
    ui_in = 8'b0001_0100;
    idle(2);
    check("clr_uo", 32'(uo_out), 32'h00);
    check("clr_uio", 32'(uio_out), 32'h00);

`ifdef ADD_MODE_EN
    send_word(8'hF0, 8'h20, 1'b1, W, 0);
    idle(3);
    check("add_F0_20", 32'({uio_out, uo_out[4]}), 32'({8'h10, 1'b1}));
`endif

    for (int k = 0; k < 25; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      n = ($urandom_range(5) == 0) ? int'($urandom_range(W - 1, 1)) : W;
      send_word(ra, rb, 1'($urandom), n, ($urandom_range(1) == 1) ? 30 : 0);
      if ($urandom_range(3) == 0) idle(int'($urandom_range(3, 1)));
    end
    idle(5);
    check("bits_left", 32'(bit_q.size()), 32'd0);
    check("words_left", 32'(word_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
